// File: rtl/lut5_cfg_loader.sv
// Serial configuration loader feeding a reconfigurable 5-input LUT.
// A 32-bit truth table is shifted into a shadow register under a
// valid/ready handshake and then committed atomically to the active table.
// O evaluates the active table combinationally from ADR4..ADR0.
module lut5_cfg_loader #(
    parameter logic [31:0] INIT      = 32'h0000_0000,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    input  logic        CDI,
    input  logic        CDI_VALID,
    output logic        CDI_READY,
    output logic        CDO,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] INIT_OUT,
    input  logic        ADR0,
    input  logic        ADR1,
    input  logic        ADR2,
    input  logic        ADR3,
    input  logic        ADR4,
    output logic        O
);

    // Handshake: a serial bit is transferred on every rising edge where
    // CDI_VALID and CDI_READY are both high. CDI_READY is high only in SHIFT
    // and depends on state alone, never on CDI_VALID. The source may hold
    // CDI_VALID low for any number of cycles; an asserted ABORT in SHIFT
    // takes precedence and the bit offered on that edge is dropped.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] active_q, active_d;
    logic        done_q, done_d;
    logic        accept;
    logic [4:0]  adr;

    // A bit is accepted only in SHIFT with valid data and no abort pending.
    assign accept = (state_q == SHIFT) && CDI_VALID && !ABORT;
    assign adr    = {ADR4, ADR3, ADR2, ADR1, ADR0};

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the 32nd acceptance always leaves SHIFT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (CDI_VALID && (cnt_q == 5'd31)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers: counter, shadow, active table and DONE pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= 5'd0;
            shadow_q <= 32'h0000_0000;
            active_q <= INIT;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Datapath next values; the active table only moves on the COMMIT exit.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        if ((state_q == IDLE) && START && !ABORT) begin
            cnt_d = 5'd0;
        end
        if (accept) begin
            cnt_d = cnt_q + 5'd1;
            if (MSB_FIRST) begin
                shadow_d = {shadow_q[30:0], CDI};
            end else begin
                shadow_d = {CDI, shadow_q[31:1]};
            end
        end
        if (state_q == COMMIT) begin
            active_d = shadow_q;
            done_d   = 1'b1;
        end
    end

    // Outputs decoded from state and registers.
    always_comb begin
        CDI_READY = (state_q == SHIFT);
        BUSY      = (state_q != IDLE);
        DONE      = done_q;
        INIT_OUT  = active_q;
        O         = active_q[adr];
        CDO       = MSB_FIRST ? shadow_q[31] : shadow_q[0];
    end

endmodule

// File: tb/tb_lut5_cfg_loader.sv
// Bench for lut5_cfg_loader: one MSB-first instance and one LSB-first
// instance share stimulus; a scoreboard queue holds the table expected at
// each DONE pulse of the instance currently under observation.
module tb_lut5_cfg_loader;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        ABORT;
    logic        CDI;
    logic        CDI_VALID;
    logic [4:0]  adr;

    logic        rdy0, cdo0, busy0, done0, o0;
    logic [31:0] tab0;
    logic        rdy1, cdo1, busy1, done1, o1;
    logic [31:0] tab1;

    logic [31:0] exp_q[$];
    int          n_chk;
    int          n_fail;
    int          done_cnt;
    bit          sel;
    int          d_before;
    logic        maj;

    lut5_cfg_loader #(.INIT(32'h8000_0000), .MSB_FIRST(1'b1)) u0 (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .CDI(CDI), .CDI_VALID(CDI_VALID), .CDI_READY(rdy0), .CDO(cdo0),
        .BUSY(busy0), .DONE(done0), .INIT_OUT(tab0),
        .ADR0(adr[0]), .ADR1(adr[1]), .ADR2(adr[2]), .ADR3(adr[3]), .ADR4(adr[4]),
        .O(o0)
    );

    lut5_cfg_loader #(.INIT(32'hA5A5_A5A5), .MSB_FIRST(1'b0)) u1 (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .CDI(CDI), .CDI_VALID(CDI_VALID), .CDI_READY(rdy1), .CDO(cdo1),
        .BUSY(busy1), .DONE(done1), .INIT_OUT(tab1),
        .ADR0(adr[0]), .ADR1(adr[1]), .ADR2(adr[2]), .ADR3(adr[3]), .ADR4(adr[4]),
        .O(o1)
    );

    // Clock generation.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each DONE of the observed instance pops one expected table.
    always @(negedge CLK) begin
        if (!RST && (sel ? done1 : done0)) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("sb_table", sel ? tab1 : tab0, exp_q.pop_front());
            end
        end
    end

    // Drivers: every task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic start_load();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        CDI       = b;
        CDI_VALID = 1'b1;
        tick();
        CDI_VALID = 1'b0;
    endtask

    // Shift bits [first_n] of w in the given order; optional 3-cycle gaps
    // after the 7th and 20th bits.
    task automatic shift_bits(input logic [31:0] w, input bit msb, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_bit(msb ? w[31 - i] : w[i]);
            if (gaps && (i == 6 || i == 19)) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check("ready_in_gap", {31'd0, sel ? rdy1 : rdy0}, 32'd1);
                end
            end
        end
    endtask

    // Full load with DONE-latency checks on the observed instance.
    task automatic full_load(input logic [31:0] w, input bit msb, input bit gaps);
        start_load();
        exp_q.push_back(w);
        shift_bits(w, msb, 32, gaps);
        check("commit_busy", {31'd0, sel ? busy1 : busy0}, 32'd1);
        check("commit_no_done", {31'd0, sel ? done1 : done0}, 32'd0);
        tick();
        check("done_latency", {31'd0, sel ? done1 : done0}, 32'd1);
        check("table_at_done", sel ? tab1 : tab0, w);
        tick();
        check("done_one_cycle", {31'd0, sel ? done1 : done0}, 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        done_cnt  = 0;
        sel       = 1'b0;
        RST       = 1'b1;
        START     = 1'b0;
        ABORT     = 1'b0;
        CDI       = 1'b0;
        CDI_VALID = 1'b0;
        adr       = 5'h1F;
        repeat (2) tick();
        do_reset();

        // Reset state of the MSB-first instance.
        check("rst_o_adr1f", {31'd0, o0}, 32'd1);
        adr = 5'h1E;
        #1;
        check("rst_o_adr1e", {31'd0, o0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_ready", {31'd0, rdy0}, 32'd0);
        check("rst_table", tab0, 32'h8000_0000);

        // Contiguous MSB-first load of a majority function.
        full_load(32'hE8E8_E8E8, 1'b1, 1'b0);
        check("cdo_after_e8", {31'd0, cdo0}, 32'd1);
        for (int a = 0; a < 32; a++) begin
            adr = a[4:0];
            #1;
            maj = (adr[0] & adr[1]) | (adr[0] & adr[2]) | (adr[1] & adr[2]);
            check("majority_o", {31'd0, o0}, {31'd0, maj});
        end

        // Same load with valid gaps; exactly one DONE.
        d_before = done_cnt;
        full_load(32'hE8E8_E8E8, 1'b1, 1'b1);
        repeat (3) tick();
        check("gap_done_count", done_cnt - d_before, 32'd1);

        // Abort after 16 bits leaves the active table alone.
        d_before = done_cnt;
        start_load();
        shift_bits(32'hFFFF_FFFF, 1'b1, 16, 1'b0);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_busy", {31'd0, busy0}, 32'd0);
        repeat (3) tick();
        check("abort_table", tab0, 32'hE8E8_E8E8);
        check("abort_no_done", done_cnt - d_before, 32'd0);
        full_load(32'h0000_FFFF, 1'b1, 1'b0);
        check("cdo_after_ffff", {31'd0, cdo0}, 32'd0);

        // Commit, then reset mid-shift; START while busy is ignored.
        full_load(32'h1234_5678, 1'b1, 1'b0);
        start_load();
        shift_bits(32'hFFFF_FFFF, 1'b1, 5, 1'b0);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_busy_stays", {31'd0, busy0}, 32'd1);
        check("start_busy_ready", {31'd0, rdy0}, 32'd1);
        shift_bits(32'hFFFF_FFFF, 1'b1, 5, 1'b0);
        check("cnt_after_10", {27'd0, u0.cnt_q}, 32'd10);
        check("pre_rst_table", tab0, 32'h1234_5678);
        do_reset();
        check("midrst_table", tab0, 32'h8000_0000);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_ready", {31'd0, rdy0}, 32'd0);
        check("midrst_done", {31'd0, done0}, 32'd0);

        // LSB-first instance.
        sel = 1'b1;
        do_reset();
        check("lsb_rst_table", tab1, 32'hA5A5_A5A5);
        full_load(32'h0000_0001, 1'b0, 1'b0);
        adr = 5'h00;
        #1;
        check("lsb_o_adr0", {31'd0, o1}, 32'd1);
        adr = 5'h01;
        #1;
        check("lsb_o_adr1", {31'd0, o1}, 32'd0);
        check("lsb_cdo", {31'd0, cdo1}, 32'd1);

        // ABORT on the same edge as the 32nd bit: no commit.
        d_before = done_cnt;
        start_load();
        shift_bits(32'hFFFF_FFFF, 1'b0, 31, 1'b0);
        ABORT = 1'b1;
        send_bit(1'b1);
        ABORT = 1'b0;
        check("abort32_busy", {31'd0, busy1}, 32'd0);
        repeat (3) tick();
        check("abort32_table", tab1, 32'h0000_0001);
        check("abort32_no_done", done_cnt - d_before, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
